data_ram: RTL and testbench
===========================

# data_ram

Data-side memory responder for the five-stage core. It answers the core's MEM-stage RAM port (`ram_ce_o`, `ram_we_o`, `ram_sel_o`, `ram_addr_o`, `ram_data_o`, `ram_data_i`) with a byte-writable word RAM and a small memory-mapped I/O window. The window holds a free-running cycle counter and a debug byte FIFO, which drains to the testbench or host through a valid/ready handshake. Reads are combinational so that a load completes within the core's single MEM cycle; all state changes occur on the rising clock edge.

## Interface
- `ADDR_W`, 10: word-address width of the RAM array (2^ADDR_W 32-bit words).
- `FIFO_DEPTH`, 8: debug FIFO depth; must be a power of 2, from 2 to 256.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ce` in 1: access enable (driven by core `ram_ce_o`).
- `we` in 1: write enable; 1 = store, 0 = load.
- `addr` in 32: byte address; bits [1:0] are ignored.
- `sel` in 4: byte-lane enables; `sel[i]` covers `data_i[8i+7:8i]`.
- `data_i` in 32: store data.
- `data_o` out 32: load data (to core `ram_data_i`).
- `dbg_data` out 8: FIFO head byte.
- `dbg_valid` out 1: FIFO non-empty.
- `dbg_ready` in 1: consumer accepts the head byte.

## Operation
- **Decode.**
  - MMIO when `addr[31:16]==16'h1000`.
  - Otherwise RAM, at word index `addr[ADDR_W+1:2]`; upper bits are ignored, so aliasing is intended.
- **RAM write.** At the edge with `ce&we`, each lane with `sel[i]=1` is written. Lanes with `sel[i]=0` keep their value.
- **RAM read.**
  - `data_o` = full word at the index when `ce&~we`. The core extracts bytes and halfwords itself.
  - `data_o` = 0 when `ce=0`, when `we=1`, or while `rst=0`.
- **RAM reset.** RAM contents are not affected by reset.
- **MMIO 0x1000_0000 CYCLE** (read/write).
  - 32-bit counter; +1 every cycle; wraps from FFFF_FFFF to 0.
  - A write with `sel==4'hF` loads `data_i`; that edge has no increment.
  - A write with a partial `sel` is ignored.
- **MMIO 0x1000_0004 DBG_TX** (write).
  - A write with `sel[0]=1` pushes `data_i[7:0]`.
  - Push while full, with no pop in the same cycle: the byte is dropped and `ovf` is set.
  - Reads return 0.
- **MMIO 0x1000_0008 STATUS.**
  - Read: `{ovf, 15'b0, 8'b0, count[7:0]}`, where `count` is the FIFO occupancy.
  - A write with `sel[3]=1` and `data_i[31]=1` clears `ovf`. All other writes are ignored.
- **Other MMIO offsets.** Reads return 0; writes are ignored.
- **FIFO.**
  - Circular buffer with read/write pointers and a `count` register.
  - `dbg_valid = (count!=0)`; `dbg_data` = entry at the read pointer.
  - Pop occurs at the edge with `dbg_valid&dbg_ready`.
  - Push and pop in the same cycle: both happen and `count` is unchanged.
  - A push while full is accepted if a pop occurs in the same cycle (no overflow).
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Reset** (`rst` low, takes effect immediately):
  - CYCLE=0, `count`=0, pointers=0, `ovf`=0.
  - `dbg_valid`=0, `dbg_data`=0, `data_o`=0.
  - A write in progress when reset asserts is discarded.

## Timing
- **Load latency.** Zero cycles: `data_o` is combinational from `addr`/`ce`/`we`, RAM contents and MMIO registers.
- **Store latency.** One edge; a load in the next cycle returns the new data.
- **CYCLE read** returns the pre-edge value. After a load of X, the next-cycle read is X, then X+1.
- **Push to consumer.** A push at edge N gives `dbg_valid=1` and `dbg_data` = the byte after edge N. There is no bypass when the FIFO is empty.
- **STATUS `count`** reflects all pushes and pops up to the last edge.
- **Reset release.** Deassertion is synchronised by the system. The first counted edge after release gives CYCLE=1.

## Test plan
- **RAM byte lanes.**
  - Stimulus: store 0x11223344 with sel=F at 0x0000_0010; store 0x0000AA00 with sel=2 at the same address; load.
  - Required: `data_o`=0x1122AA44.
  - Also: a load at 0x0000_1010 with ADDR_W=10 returns the same word (aliasing).
- **Read gating.** With `ce=0`, and separately with `we=1`: `data_o`=0 regardless of RAM contents.
- **CYCLE counter.**
  - Write 0xFFFF_FFFE (sel=F) → reads on the following cycles return FFFF_FFFE, FFFF_FFFF, 0000_0000.
  - A write with sel=1 → counter is unaffected.
- **FIFO fill, overflow, drain.**
  - With `dbg_ready=0`, push 0x41..0x49 (9 bytes).
  - Required: STATUS reads 0x8000_0008 and the 0x49 byte is lost.
  - Assert `dbg_ready`: the bytes 0x41..0x48 appear in order, one per cycle, then `dbg_valid`=0.
  - Clearing via STATUS → STATUS reads 0.
- **Full push+pop.** With the FIFO full and `dbg_ready=1`, push 0x5A in the same cycle → `count` stays 8, `ovf` stays 0, and 0x5A is the last byte drained.
- **Async reset mid-operation.** Pull `rst` low between edges while the FIFO holds 3 bytes and CYCLE=100 → immediately `dbg_valid`=0 and `data_o`=0; after release, STATUS=0 and RAM contents are unchanged.

Source files
------------

// File: rtl/data_ram.sv
// data_ram: data-side memory responder for the five-stage core.
//
// Byte-writable word RAM plus a small MMIO window at 0x1000_xxxx:
//   0x1000_0000 CYCLE   free-running 32-bit counter (full-word write loads it)
//   0x1000_0004 DBG_TX  write pushes data_i[7:0] into the debug FIFO
//   0x1000_0008 STATUS  {ovf, 23'b0, count[7:0]}; write with sel[3] & data_i[31] clears ovf
// Loads are combinational (single MEM cycle); all state changes on rising clk.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   ce, we          access enable, write enable (1 = store)
//   addr            byte address, bits [1:0] ignored
//   sel             byte-lane enables for stores
//   data_i / data_o store data / load data (0 unless a load is active)
//   dbg_data        FIFO head byte
//   dbg_valid       FIFO non-empty
//   dbg_ready       consumer pops the head byte at the next edge

// One byte lane of the RAM array. Contents are deliberately not reset.
module data_ram_lane #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);
  logic [7:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_idx] <= i_wdata;

  assign o_rdata = r_mem[i_idx];
endmodule

module data_ram #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [7:0]  dbg_data,
  output logic        dbg_valid,
  input  logic        dbg_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // ---------------- decode ----------------
  logic              w_mmio, w_wr, w_rd;
  logic              w_is_cyc, w_is_tx, w_is_stat;
  logic [ADDR_W-1:0] w_idx;
  logic [13:0]       w_off;

  // rst gating keeps a store that overlaps reset from landing in the RAM
  assign w_mmio    = (addr[31:16] == 16'h1000);
  assign w_wr      = rst & ce & we;
  assign w_rd      = rst & ce & ~we;
  assign w_idx     = addr[ADDR_W+1:2];
  assign w_off     = addr[15:2];
  assign w_is_cyc  = w_mmio && (w_off == 14'd0);
  assign w_is_tx   = w_mmio && (w_off == 14'd1);
  assign w_is_stat = w_mmio && (w_off == 14'd2);

  // Only part of addr feeds the decode; fold the rest into a sink.
  logic w_unused;
  assign w_unused = &{1'b0, addr};

  // ---------------- RAM ----------------
  logic [3:0]      w_ram_we;
  logic [3:0][7:0] w_ram_rd;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign w_ram_we[i] = w_wr & ~w_mmio & sel[i];
    data_ram_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk     (clk),
      .i_we    (w_ram_we[i]),
      .i_idx   (w_idx),
      .i_wdata (data_i[8*i +: 8]),
      .o_rdata (w_ram_rd[i])
    );
  end

  // ---------------- CYCLE ----------------
  logic [31:0] r_cycle;

  always_ff @(posedge clk or negedge rst)
    if (!rst)                                    r_cycle <= '0;
    else if (w_wr && w_is_cyc && sel == 4'hF)    r_cycle <= data_i;
    else                                         r_cycle <= r_cycle + 32'd1;

  // ---------------- debug FIFO ----------------
  logic [7:0]    r_buf [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_push, w_pop, w_full, w_accept, w_clr;

  assign w_push   = w_wr & w_is_tx & sel[0];
  assign w_pop    = dbg_valid & dbg_ready;
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_clr    = w_wr & w_is_stat & sel[3] & data_i[31];

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) r_buf[k] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf[r_wptr] <= data_i[7:0];
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_clr)                          r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end

  assign dbg_valid = (r_count != '0);
  assign dbg_data  = r_buf[r_rptr];

  // STATUS count field is 8 bits wide whatever the FIFO depth
  logic [7:0] w_cnt8;
  if (CW >= 8) begin : g_cnt_trunc
    assign w_cnt8 = r_count[7:0];
  end else begin : g_cnt_ext
    assign w_cnt8 = {{(8-CW){1'b0}}, r_count};
  end

  // ---------------- load mux ----------------
  always_comb begin
    data_o = '0;
    if (w_rd) begin
      if (w_mmio) begin
        if (w_is_cyc)       data_o = r_cycle;
        else if (w_is_stat) data_o = {r_ovf, 23'b0, w_cnt8};
      end else begin
        data_o = w_ram_rd;
      end
    end
  end
endmodule

// File: tb/tb_data_ram.sv
module tb_data_ram;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce, we, dbg_ready;
  logic [31:0] addr, data_i, data_o;
  logic [3:0]  sel;
  logic [7:0]  dbg_data;
  logic        dbg_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_ram #(.ADDR_W(10), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .dbg_data(dbg_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready)
  );

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam logic [31:0] A_CYC  = 32'h1000_0000;
  localparam logic [31:0] A_TX   = 32'h1000_0004;
  localparam logic [31:0] A_STAT = 32'h1000_0008;

  function automatic vec_t mk(input logic c, input logic w, input logic [31:0] a,
                              input logic [3:0] s, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.ce = c; v.we = w; v.addr = a; v.sel = s; v.wdata = d; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic c, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d);
    ce = c; we = w; addr = a; sel = s; data_i = d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a);
    drv(1'b1, 1'b0, a, 4'h0, 32'h0);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    drv(1'b1, 1'b1, A_TX, 4'h1, {24'h0, b});
    step();
  endtask

  vec_t vt[20];
  logic [7:0] exp_b[8];

  initial begin
    // reset state, checked while a load is presented
    drv(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    dbg_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_valid", {31'h0, dbg_valid}, 32'h0);
    chk("rst_dbg_data", {24'h0, dbg_data}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ce we addr sel wdata expected data_o (sampled before the edge)
    vt[0]  = mk(1, 1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0);
    vt[1]  = mk(1, 1, 32'h0000_0010, 4'h2, 32'h0000_AA00, 32'h0);
    vt[2]  = mk(1, 0, 32'h0000_0010, 4'h0, 32'h0,         32'h1122_AA44);
    vt[3]  = mk(1, 0, 32'h0000_1010, 4'h0, 32'h0,         32'h1122_AA44);
    vt[4]  = mk(0, 0, 32'h0000_0010, 4'h0, 32'h0,         32'h0);
    vt[5]  = mk(1, 1, 32'h1000_0010, 4'hF, 32'hBAD0_BAD0, 32'h0);
    vt[6]  = mk(1, 0, 32'h0000_0010, 4'h0, 32'h0,         32'h1122_AA44);
    vt[7]  = mk(1, 1, 32'h0000_0014, 4'hF, 32'hCAFE_F00D, 32'h0);
    vt[8]  = mk(1, 1, 32'h0000_0017, 4'h8, 32'h7700_0000, 32'h0);
    vt[9]  = mk(1, 0, 32'h0000_0014, 4'h0, 32'h0,         32'h77FE_F00D);
    vt[10] = mk(1, 1, A_CYC,         4'hF, 32'hFFFF_FFFE, 32'h0);
    vt[11] = mk(1, 0, A_CYC,         4'h0, 32'h0,         32'hFFFF_FFFE);
    vt[12] = mk(1, 0, A_CYC,         4'h0, 32'h0,         32'hFFFF_FFFF);
    vt[13] = mk(1, 0, A_CYC,         4'h0, 32'h0,         32'h0000_0000);
    vt[14] = mk(1, 1, A_CYC,         4'h1, 32'h0000_1234, 32'h0);
    vt[15] = mk(1, 0, A_CYC,         4'h0, 32'h0,         32'h0000_0002);
    vt[16] = mk(1, 0, A_TX,          4'h0, 32'h0,         32'h0);
    vt[17] = mk(1, 0, 32'h1000_000C, 4'h0, 32'h0,         32'h0);
    vt[18] = mk(1, 0, A_STAT,        4'h0, 32'h0,         32'h0);
    vt[19] = mk(1, 1, A_STAT,        4'h7, 32'h8000_0000, 32'h0);

    for (int i = 0; i < 20; i++) begin
      drv(vt[i].ce, vt[i].we, vt[i].addr, vt[i].sel, vt[i].wdata);
      #1;
      chk($sformatf("vec%0d", i), data_o, vt[i].exp);
      step();
    end

    // FIFO fill past full, then drain
    drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1;
    chk("fifo_empty_valid", {31'h0, dbg_valid}, 32'h0);
    push(8'h41);
    chk("push1_valid", {31'h0, dbg_valid}, 32'h1);
    chk("push1_data", {24'h0, dbg_data}, 32'h41);
    for (int i = 1; i < 9; i++) push(8'(8'h41 + i));
    rd(A_STAT);
    chk("ovf_status", data_o, 32'h8000_0008);
    chk("ovf_head", {24'h0, dbg_data}, 32'h41);
    drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    dbg_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("drain%0d_valid", i), {31'h0, dbg_valid}, 32'h1);
      chk($sformatf("drain%0d_data", i), {24'h0, dbg_data}, 32'(8'h41 + i));
      step();
    end
    #1;
    chk("drained_valid", {31'h0, dbg_valid}, 32'h0);
    dbg_ready = 1'b0;
    rd(A_STAT);
    chk("ovf_sticky", data_o, 32'h8000_0000);
    drv(1'b1, 1'b1, A_STAT, 4'h8, 32'h8000_0000);
    step();
    rd(A_STAT);
    chk("ovf_cleared", data_o, 32'h0);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
    rd(A_STAT);
    chk("full_status", data_o, 32'h0000_0008);
    dbg_ready = 1'b1;
    drv(1'b1, 1'b1, A_TX, 4'h1, 32'h0000_005A);
    step();
    dbg_ready = 1'b0;
    rd(A_STAT);
    chk("pushpop_status", data_o, 32'h0000_0008);
    for (int i = 0; i < 7; i++) exp_b[i] = 8'(8'h51 + i);
    exp_b[7] = 8'h5A;
    drv(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    dbg_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("pp_drain%0d", i), {23'h0, dbg_valid, dbg_data}, {23'h0, 1'b1, exp_b[i]});
      step();
    end
    #1;
    chk("pp_drained_valid", {31'h0, dbg_valid}, 32'h0);
    dbg_ready = 1'b0;

    // asynchronous reset mid-operation
    drv(1'b1, 1'b1, A_CYC, 4'hF, 32'd97);
    step();
    push(8'h61);
    push(8'h62);
    push(8'h63);
    rd(A_CYC);
    chk("pre_rst_cycle", data_o, 32'd100);
    rd(A_STAT);
    chk("pre_rst_status", data_o, 32'h0000_0003);
    rd(32'h0000_0010);
    chk("pre_rst_ram", data_o, 32'h1122_AA44);
    rst = 1'b0;
    #1;
    chk("async_data_o", data_o, 32'h0);
    chk("async_valid", {31'h0, dbg_valid}, 32'h0);
    chk("async_dbg_data", {24'h0, dbg_data}, 32'h0);
    drv(1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF);
    step();
    rst = 1'b1;
    rd(32'h0000_0010);
    chk("post_rst_ram", data_o, 32'h1122_AA44);
    rd(A_STAT);
    chk("post_rst_status", data_o, 32'h0);
    rd(A_CYC);
    chk("post_rst_cycle0", data_o, 32'h0);
    step();
    #1;
    chk("post_rst_cycle1", data_o, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
